sram_sdp_be: RTL and testbench

//  Simple dual-port SRAM: one write port, one read port, per-byte write enables.

---
 rtl/sram_sdp_be_pkg.sv | 24 ++
 rtl/sram_sdp_be_clr.sv | 62 ++++++
 rtl/sram_sdp_be.sv | 195 +++++++++++++++++++
 tb/tb_sram_sdp_be.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_sdp_be_pkg.sv
// Shared types and helpers for the simple dual-port byte-enable SRAM.
// Holds the clear-sequencer state type, the read-latency ceiling and the
// per-byte parity helper used when SRAM_PARITY_EN is defined.
package sram_sdp_be_pkg;

    localparam int RD_LAT_MAX     = 2;
    localparam int MAX_DATA_WIDTH = 1024;
    localparam int MAX_NB         = MAX_DATA_WIDTH / 8;

    typedef enum logic {SRAM_INIT, SRAM_READY} sram_state_e;

    // Even parity per byte lane: bit b makes lane b plus its parity bit hold
    // an even number of ones. Callers zero-extend narrower words into d and
    // keep only their own low lanes of the result.
    function automatic logic [MAX_NB-1:0] byte_parity(input logic [MAX_DATA_WIDTH-1:0] d);
        logic [MAX_NB-1:0] p;
        p = '0;
        for (int b = 0; b < MAX_NB; b++) begin
            p[b] = ^d[8*b +: 8];
        end
        return p;
    endfunction

endpackage

// File: rtl/sram_sdp_be_clr.sv
// Clear sequencer for sram_sdp_be: after reset it walks every word address
// once, asking the top level to write zero there, then settles in READY
// until the next reset. busy is high for the whole sweep.
module sram_clr_seq
    import sram_sdp_be_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    sram_state_e           state;
    sram_state_e           state_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    // State and sweep-address register; reset restarts the sweep at word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SRAM_INIT;
            clr_addr <= '0;
        end else begin
            state    <= state_next;
            clr_addr <= addr_next;
        end
    end

    // Sweep one word per cycle, leaving INIT once the last word is cleared.
    always_comb begin
        state_next = state;
        addr_next  = clr_addr;
        busy       = 1'b0;
        clr_we     = 1'b0;
        case (state)
            SRAM_INIT: begin
                busy   = 1'b1;
                clr_we = 1'b1;
                if (clr_addr == LAST_ADDR) begin
                    state_next = SRAM_READY;
                    addr_next  = '0;
                end else begin
                    addr_next = clr_addr + ADDR_WIDTH'(1);
                end
            end
            SRAM_READY: begin
                busy = 1'b0;
            end
            default: begin
                state_next = SRAM_INIT;
                addr_next  = '0;
                busy       = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/sram_sdp_be.sv
// Simple dual-port SRAM with per-byte write enables, a zeroing sweep after
// reset and a read latency of 1 or 2 cycles.
// Optional feature: define SRAM_PARITY_EN to store one even-parity bit per
// byte lane and flag mismatches on perr_o; otherwise perr_o is tied low.
module sram_sdp_be
    import sram_sdp_be_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int NB         = DATA_WIDTH / 8,
    parameter int RD_LAT     = 1,
    parameter bit RDW_NEW    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [NB-1:0]         be_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  busy_o,
    output logic                  perr_o
);

    localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    logic                  busy;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;

    logic                  waddr_ok;
    logic                  raddr_ok;
    logic                  wr_en;
    logic                  rd_en;
    logic                  same_addr;
    logic [DATA_WIDTH-1:0] be_mask;

    logic [DATA_WIDTH-1:0] mem_data [DEPTH];

    logic [DATA_WIDTH-1:0] rd_word;
    logic                  rd_perr;

    logic                  rd_vld_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_perr_q;

    sram_clr_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst_i),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign busy_o = busy;

    // User accesses only count once the sweep is done and reset is released;
    // out-of-range writes are discarded here, out-of-range reads return zero.
    always_comb begin
        waddr_ok  = {1'b0, waddr_i} < DEPTH_EXT;
        raddr_ok  = {1'b0, raddr_i} < DEPTH_EXT;
        wr_en     = we_i & ~busy & ~rst_i & waddr_ok;
        rd_en     = re_i & ~busy & ~rst_i;
        same_addr = (waddr_i == raddr_i);
        be_mask   = '0;
        for (int b = 0; b < NB; b++) begin
            be_mask[8*b +: 8] = {8{be_i[b]}};
        end
    end

    // Data array write: the clear sweep owns the port while it runs,
    // otherwise only the enabled byte lanes of the addressed word change.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_data[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_data[waddr_i] <= (mem_data[waddr_i] & ~be_mask) | (wdata_i & be_mask);
        end
    end

    // Read word as seen at the request edge, optionally bypassing the
    // enabled lanes of a same-cycle write to the same address.
    always_comb begin
        rd_word = '0;
        if (raddr_ok) begin
            rd_word = mem_data[raddr_i];
        end
        if (RDW_NEW && wr_en && same_addr) begin
            rd_word = (rd_word & ~be_mask) | (wdata_i & be_mask);
        end
    end

`ifdef SRAM_PARITY_EN
    logic [NB-1:0]             mem_par [DEPTH];
    logic [MAX_DATA_WIDTH-1:0] wdata_ext;
    logic [MAX_DATA_WIDTH-1:0] rword_ext;
    logic [MAX_NB-1:0]         wpar_full;
    logic [MAX_NB-1:0]         rpar_full;
    logic [NB-1:0]             wpar;
    logic [NB-1:0]             rd_par_stored;
    logic                      unused_par;

    // Parity of the incoming write data and of the word being read out.
    always_comb begin
        wdata_ext                   = '0;
        wdata_ext[DATA_WIDTH-1:0]   = wdata_i;
        rword_ext                   = '0;
        rword_ext[DATA_WIDTH-1:0]   = rd_word;
        wpar_full                   = byte_parity(wdata_ext);
        rpar_full                   = byte_parity(rword_ext);
        wpar                        = wpar_full[NB-1:0];
    end

    assign unused_par = ^{wpar_full[MAX_NB-1:NB], rpar_full[MAX_NB-1:NB]};

    // Parity array write tracks the data array lane for lane.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_par[clr_addr] <= '0;
        end else if (wr_en) begin
            mem_par[waddr_i] <= (mem_par[waddr_i] & ~be_i) | (wpar & be_i);
        end
    end

    // Stored parity for the read, with bypassed lanes taking the fresh parity;
    // out-of-range reads never report an error.
    always_comb begin
        rd_par_stored = '0;
        if (raddr_ok) begin
            rd_par_stored = mem_par[raddr_i];
        end
        if (RDW_NEW && wr_en && same_addr) begin
            rd_par_stored = (rd_par_stored & ~be_i) | (wpar & be_i);
        end
        rd_perr = raddr_ok & (|(rpar_full[NB-1:0] ^ rd_par_stored));
    end
`else
    assign rd_perr = 1'b0;
`endif

    // First read stage: capture the word at the request edge; data holds
    // between reads, valid and parity error pulse with the result.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
            rd_perr_q <= 1'b0;
        end else begin
            rd_vld_q  <= rd_en;
            rd_perr_q <= rd_en & rd_perr;
            if (rd_en) begin
                rd_data_q <= rd_word;
            end
        end
    end

    generate
        if (RD_LAT >= RD_LAT_MAX) begin : g_out_reg
            logic                  out_vld_q;
            logic [DATA_WIDTH-1:0] out_data_q;
            logic                  out_perr_q;

            // Optional output register adding the second cycle of latency.
            always_ff @(posedge clk) begin
                if (rst_i) begin
                    out_vld_q  <= 1'b0;
                    out_data_q <= '0;
                    out_perr_q <= 1'b0;
                end else begin
                    out_vld_q  <= rd_vld_q;
                    out_perr_q <= rd_perr_q;
                    if (rd_vld_q) begin
                        out_data_q <= rd_data_q;
                    end
                end
            end

            assign rvalid_o = out_vld_q;
            assign rdata_o  = out_data_q;
            assign perr_o   = out_perr_q;
        end else begin : g_no_out_reg
            assign rvalid_o = rd_vld_q;
            assign rdata_o  = rd_data_q;
            assign perr_o   = rd_perr_q;
        end
    endgenerate

endmodule

// File: tb/tb_sram_sdp_be.sv
// Scoreboard bench for sram_sdp_be. Two instances share one stimulus stream:
// dut_a uses the defaults (DEPTH 16, RD_LAT 1, old data on collision) and
// dut_b uses DEPTH 12, RD_LAT 2 and new data on collision, so it also sees
// out-of-range addresses 12..15.
module tb_sram_sdp_be;

    localparam int DW    = 32;
    localparam int NBL   = DW / 8;
    localparam int AW    = 4;
    localparam int DEP_A = 16;
    localparam int DEP_B = 12;
    localparam int LAT_A = 1;
    localparam int LAT_B = 2;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        perr;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            we;
    logic            re;
    logic [AW-1:0]   waddr;
    logic [AW-1:0]   raddr;
    logic [DW-1:0]   wdata;
    logic [NBL-1:0]  be;

    logic [DW-1:0]   rdata_a, rdata_b;
    logic            rvalid_a, rvalid_b;
    logic            busy_a, busy_b;
    logic            perr_a, perr_b;

    int              cyc = 0;
    int              vectors = 0;
    int              miscompares = 0;
    int              rst_edges[$];
    exp_t            q_a[$];
    exp_t            q_b[$];
    logic [31:0]     mdl_mem [2][16];
    logic [3:0]      lanebad [2][16];
    logic [31:0]     last_rdata [2];

    sram_sdp_be #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP_A),
        .RD_LAT     (LAT_A),
        .RDW_NEW    (1'b0)
    ) dut_a (
        .clk      (clk),
        .rst_i    (rst),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .be_i     (be),
        .re_i     (re),
        .raddr_i  (raddr),
        .rdata_o  (rdata_a),
        .rvalid_o (rvalid_a),
        .busy_o   (busy_a),
        .perr_o   (perr_a)
    );

    sram_sdp_be #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEP_B),
        .RD_LAT     (LAT_B),
        .RDW_NEW    (1'b1)
    ) dut_b (
        .clk      (clk),
        .rst_i    (rst),
        .we_i     (we),
        .waddr_i  (waddr),
        .wdata_i  (wdata),
        .be_i     (be),
        .re_i     (re),
        .raddr_i  (raddr),
        .rdata_o  (rdata_b),
        .rvalid_o (rvalid_b),
        .busy_o   (busy_b),
        .perr_o   (perr_b)
    );

    // Free-running clock and edge counter used to time expected results.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int latestReset(input int c);
        int r;
        r = -1;
        foreach (rst_edges[i]) begin
            if (rst_edges[i] <= c) r = rst_edges[i];
        end
        return r;
    endfunction

    // Busy lasts for the DEPTH cycles following the latest reset edge.
    function automatic bit busyAt(input int c, input int dep);
        int r;
        r = latestReset(c);
        return (r >= 0) && ((c - r) < dep);
    endfunction

    function automatic logic [31:0] mergeLanes(input logic [31:0] oldw, input logic [31:0] neww,
                                               input logic [3:0] en);
        logic [31:0] res;
        res = oldw;
        for (int b = 0; b < 4; b++) begin
            if (en[b]) res[8*b +: 8] = neww[8*b +: 8];
        end
        return res;
    endfunction

    function automatic int qSize(input int d);
        return (d == 0) ? q_a.size() : q_b.size();
    endfunction

    function automatic exp_t qFront(input int d);
        exp_t ex;
        if (d == 0) ex = q_a[0];
        else        ex = q_b[0];
        return ex;
    endfunction

    function automatic void qPop(input int d);
        if (d == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
    endfunction

    function automatic void qPush(input int d, input exp_t ex);
        if (d == 0) q_a.push_back(ex);
        else        q_b.push_back(ex);
    endfunction

    // Reset cancels every result due at or after the reset edge.
    function automatic void purgeFrom(input int e);
        while (q_a.size() > 0 && q_a[q_a.size()-1].cyc >= e) void'(q_a.pop_back());
        while (q_b.size() > 0 && q_b[q_b.size()-1].cyc >= e) void'(q_b.pop_back());
    endfunction

    // Reference behaviour of one instance for an access presented at edge e.
    task automatic modelAccess(input int d, input int e, input logic w, input logic rd,
                               input logic [3:0] wa, input logic [31:0] wd,
                               input logic [3:0] b, input logic [3:0] ra);
        int   dep;
        int   lat;
        bit   rnew;
        bit   wr_ok;
        exp_t ex;
        logic [3:0] bad;
        dep  = (d == 0) ? DEP_A : DEP_B;
        lat  = (d == 0) ? LAT_A : LAT_B;
        rnew = (d != 0);
        if (busyAt(e - 1, dep)) return;
        wr_ok = w && (int'(wa) < dep);
        if (rd) begin
            ex.cyc  = e + lat - 1;
            ex.data = '0;
            ex.perr = 1'b0;
            if (int'(ra) < dep) begin
                ex.data = mdl_mem[d][ra];
                bad     = lanebad[d][ra];
                if (rnew && wr_ok && wa == ra) begin
                    ex.data = mergeLanes(ex.data, wd, b);
                    bad     = bad & ~b;
                end
                ex.perr = |bad;
            end
            qPush(d, ex);
        end
        if (wr_ok) begin
            mdl_mem[d][wa] = mergeLanes(mdl_mem[d][wa], wd, b);
            lanebad[d][wa] = lanebad[d][wa] & ~b;
        end
    endtask

    // Drive one cycle of inputs shortly after a rising edge and log the
    // expected consequences for the next edge.
    task automatic applyStimulus(input logic r, input logic w, input logic rd,
                                 input logic [3:0] wa, input logic [31:0] wd,
                                 input logic [3:0] b, input logic [3:0] ra);
        int e;
        @(posedge clk);
        #2;
        rst   = r;
        we    = w;
        re    = rd;
        waddr = wa;
        wdata = wd;
        be    = b;
        raddr = ra;
        e     = cyc + 1;
        if (r) begin
            rst_edges.push_back(e);
            purgeFrom(e);
            for (int d = 0; d < 2; d++) begin
                for (int a = 0; a < 16; a++) begin
                    mdl_mem[d][a] = '0;
                    lanebad[d][a] = '0;
                end
            end
        end else begin
            modelAccess(0, e, w, rd, wa, wd, b, ra);
            modelAccess(1, e, w, rd, wa, wd, b, ra);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    endtask

    // Compare one instance's outputs against the scoreboard for this cycle.
    task automatic checkOutput(input int d, input logic rv, input logic [31:0] rd,
                               input logic pe, input logic bz);
        int   dep;
        exp_t ex;
        dep = (d == 0) ? DEP_A : DEP_B;
        if (latestReset(cyc) == cyc) last_rdata[d] = '0;

        vectors++;
        if (bz !== busyAt(cyc, dep)) begin
            miscompares++;
            $display("[TB] FAIL busy dut%0d cyc %0d: got %b expected %b", d, cyc, bz, busyAt(cyc, dep));
        end

        while (qSize(d) > 0) begin
            ex = qFront(d);
            if (ex.cyc >= cyc) break;
            vectors++;
            miscompares++;
            $display("[TB] FAIL missing_rvalid dut%0d cyc %0d: got none expected data %h at cyc %0d",
                     d, cyc, ex.data, ex.cyc);
            qPop(d);
        end

        vectors++;
        if (rv === 1'b1) begin
            if (qSize(d) == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_rvalid dut%0d cyc %0d: got rvalid=1 data %h expected no read",
                         d, cyc, rd);
            end else begin
                ex = qFront(d);
                if (ex.cyc != cyc) begin
                    miscompares++;
                    $display("[TB] FAIL early_rvalid dut%0d cyc %0d: got rvalid=1 expected at cyc %0d",
                             d, cyc, ex.cyc);
                end else begin
                    qPop(d);
                    last_rdata[d] = ex.data;
                    if (rd !== ex.data || pe !== ex.perr) begin
                        miscompares++;
                        $display("[TB] FAIL rdata dut%0d cyc %0d: got %h perr %b expected %h perr %b",
                                 d, cyc, rd, pe, ex.data, ex.perr);
                    end
                end
            end
        end else if (rv !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rvalid_x dut%0d cyc %0d: got %b expected 0 or 1", d, cyc, rv);
        end else if (rd !== last_rdata[d] || pe !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL hold dut%0d cyc %0d: got %h perr %b expected %h perr 0",
                     d, cyc, rd, pe, last_rdata[d]);
        end
    endtask

    // Monitor: sample both instances on the falling edge once reset has been seen.
    always @(negedge clk) begin
        if (latestReset(cyc) >= 0) begin
            checkOutput(0, rvalid_a, rdata_a, perr_a, busy_a);
            checkOutput(1, rvalid_b, rdata_b, perr_b, busy_b);
        end
    end

    // Directed scenarios followed by a randomized stream.
    initial begin
        logic [3:0]  wa;
        logic [3:0]  ra;
        logic [3:0]  b;
        logic        w;
        logic        rd;
        logic        r;
        rst   = 1'b1;
        we    = 1'b0;
        re    = 1'b0;
        waddr = '0;
        raddr = '0;
        wdata = '0;
        be    = '0;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        $display("[TB] start");

        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 4'd3);
        idle(DEP_A + 1);

        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 4'd0, 4'(i));

        applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 32'h11223344, 4'hF, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 32'hAABBCCDD, 4'b0101, 4'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 4'd0, 4'd5);
        idle(3);

        applyStimulus(1'b0, 1'b1, 1'b1, 4'd7, 32'hCAFEF00D, 4'hF, 4'd7);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 4'd0, 4'd7);
        idle(3);

        for (int i = 0; i < 16; i++) begin
            if (i == 9) applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
            else        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 4'd0, 4'(i));
        end
        idle(DEP_A + 2);

        for (int k = 0; k < 400; k++) begin
            r  = (k == 200);
            w  = ($urandom_range(0, 1) == 1);
            rd = ($urandom_range(0, 3) != 0);
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            applyStimulus(r, w, rd, wa, $urandom, b, ra);
        end
        idle(3);

`ifdef SRAM_PARITY_EN
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 32'h000000FF, 4'hF, 4'd0);
        idle(2);
        @(posedge clk);
        #1;
        dut_a.mem_data[2] = dut_a.mem_data[2] ^ 32'h1;
        mdl_mem[0][2]     = mdl_mem[0][2] ^ 32'h1;
        lanebad[0][2][0]  = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 4'd0, 4'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, 32'd0, 4'd0, 4'd1);
        idle(3);
`endif

        idle(4);
        @(posedge clk);
        #3;
        vectors++;
        if (q_a.size() + q_b.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d results outstanding expected 0", q_a.size() + q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
